// File: rtl/axi_lite_regfile_slave.sv
// AXI-Lite register bank: control/status/scratch/version/interrupt registers for an accelerator core.
// Write address and data are captured independently; the commit fires once both are held.
module axi_lite_regfile_slave #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] VERSION    = 32'h0001_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    input  logic                    core_busy,
    input  logic                    core_done,
    output logic                    ctrl_start,
    output logic [3:0]              ctrl_mode,
    output logic                    irq
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_STATUS   = 3'd1,
        REG_SCRATCH0 = 3'd2,
        REG_SCRATCH1 = 3'd3,
        REG_VERSION  = 3'd4,
        REG_IRQ_STAT = 3'd5,
        REG_IRQ_EN   = 3'd6,
        REG_NONE     = 3'd7
    } reg_sel_e;

    function automatic reg_sel_e decode(input logic [IDX_W-1:0] idx);
        reg_sel_e sel;
        sel = REG_NONE;
        if (idx[IDX_W-1:3] == '0) begin
            case (idx[2:0])
                3'd0:    sel = REG_CTRL;
                3'd1:    sel = REG_STATUS;
                3'd2:    sel = REG_SCRATCH0;
                3'd3:    sel = REG_SCRATCH1;
                3'd4:    sel = REG_VERSION;
                3'd5:    sel = REG_IRQ_STAT;
                3'd6:    sel = REG_IRQ_EN;
                default: sel = REG_NONE;
            endcase
        end
        return sel;
    endfunction

    // Write channel state
    logic                    aw_held_q, aw_held_d;
    logic [IDX_W-1:0]        awidx_q, awidx_d;
    logic                    w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;

    // Read channel state
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;

    // Register file
    logic [3:0]              mode_q, mode_d;
    logic                    start_q, start_d;
    logic [DATA_WIDTH-1:0]   scratch0_q, scratch0_d;
    logic [DATA_WIDTH-1:0]   scratch1_q, scratch1_d;
    logic                    irq_stat_q, irq_stat_d;
    logic                    irq_en_q, irq_en_d;

    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
    reg_sel_e                wsel, rsel;
    logic [DATA_WIDTH-1:0]   wmask;
    logic                    irq_clr;
    logic                    unused_ok;

    assign aw_hs  = s_axi_awvalid & awready_q;
    assign w_hs   = s_axi_wvalid & wready_q;
    assign b_hs   = bvalid_q & s_axi_bready;
    assign ar_hs  = s_axi_arvalid & arready_q;
    assign r_hs   = rvalid_q & s_axi_rready;
    assign commit = aw_held_q & w_held_q;
    assign wsel   = decode(awidx_q);
    assign rsel   = decode(s_axi_araddr[ADDR_WIDTH-1:2]);

    always_comb begin
        wmask = '0;
        for (int unsigned i = 0; i < DATA_WIDTH/8; i++) begin
            wmask[i*8 +: 8] = {8{wstrb_q[i]}};
        end
    end

    always_comb begin
        aw_held_d = aw_held_q;
        awidx_d   = awidx_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            awidx_d   = s_axi_awaddr[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (wsel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
        end else if (b_hs) begin
            bvalid_d = 1'b0;
        end
        // Readies are registered from next state so they are 0 in reset yet track held/bvalid exactly.
        awready_d = ~aw_held_d & ~bvalid_d;
        wready_d  = ~w_held_d & ~bvalid_d;
    end

    always_comb begin
        mode_d     = mode_q;
        start_d    = 1'b0;
        scratch0_d = scratch0_q;
        scratch1_d = scratch1_q;
        irq_en_d   = irq_en_q;
        irq_clr    = 1'b0;
        if (commit) begin
            case (wsel)
                REG_CTRL: begin
                    if (wstrb_q[0]) begin
                        mode_d  = wdata_q[7:4];
                        start_d = wdata_q[0];
                    end
                end
                REG_SCRATCH0: scratch0_d = (scratch0_q & ~wmask) | (wdata_q & wmask);
                REG_SCRATCH1: scratch1_d = (scratch1_q & ~wmask) | (wdata_q & wmask);
                REG_IRQ_STAT: irq_clr    = wstrb_q[0] & wdata_q[0];
                REG_IRQ_EN: begin
                    if (wstrb_q[0]) irq_en_d = wdata_q[0];
                end
                default: ;
            endcase
        end
        // A done pulse in the same cycle as a W1C clear keeps the flag set.
        irq_stat_d = (irq_stat_q & ~irq_clr) | core_done;
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_OKAY;
            case (rsel)
                REG_CTRL:     rdata_d[7:4] = mode_q;
                REG_STATUS:   rdata_d[0]   = core_busy;
                REG_SCRATCH0: rdata_d      = scratch0_q;
                REG_SCRATCH1: rdata_d      = scratch1_q;
                REG_VERSION:  rdata_d      = VERSION;
                REG_IRQ_STAT: rdata_d[0]   = irq_stat_q;
                REG_IRQ_EN:   rdata_d[0]   = irq_en_q;
                default:      rresp_d      = RESP_SLVERR;
            endcase
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end
        arready_d = ~rvalid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held_q  <= 1'b0;
            awidx_q    <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            mode_q     <= '0;
            start_q    <= 1'b0;
            scratch0_q <= '0;
            scratch1_q <= '0;
            irq_stat_q <= 1'b0;
            irq_en_q   <= 1'b0;
        end else begin
            aw_held_q  <= aw_held_d;
            awidx_q    <= awidx_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            mode_q     <= mode_d;
            start_q    <= start_d;
            scratch0_q <= scratch0_d;
            scratch1_q <= scratch1_d;
            irq_stat_q <= irq_stat_d;
            irq_en_q   <= irq_en_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign ctrl_start    = start_q;
    assign ctrl_mode     = mode_q;
    assign irq           = irq_stat_q & irq_en_q;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed bench for axi_lite_regfile_slave: handshake timing, register map, strobes, IRQ and async reset.
`timescale 1ns/1ps
module tb_axi_lite_regfile_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  s_axi_awaddr = '0;
    logic [2:0]  s_axi_awprot = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [7:0]  s_axi_araddr = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic        core_busy = 1'b0;
    logic        core_done = 1'b0;
    logic        ctrl_start;
    logic [3:0]  ctrl_mode;
    logic        irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_lite_regfile_slave #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32),
        .VERSION(32'h0001_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .core_busy(core_busy), .core_done(core_done),
        .ctrl_start(ctrl_start), .ctrl_mode(ctrl_mode), .irq(irq)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_done, w_done, a_acc, d_acc;
        int n;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b1;
        aw_done = 1'b0;
        w_done  = 1'b0;
        n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            a_acc = s_axi_awvalid && s_axi_awready;
            d_acc = s_axi_wvalid && s_axi_wready;
            tick();
            n++;
            if (a_acc) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
            if (d_acc) begin w_done = 1'b1; s_axi_wvalid = 1'b0; end
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        total++;
        if (!(aw_done && w_done)) begin
            bad++;
            $display("FAIL write_handshake addr=%h aw=%0b w=%0b required both 1", addr, aw_done, w_done);
        end
        n = 0;
        while (s_axi_bvalid !== 1'b1 && n < 20) begin tick(); n++; end
        total++;
        if (s_axi_bvalid !== 1'b1) begin
            bad++;
            $display("FAIL write_bvalid addr=%h got=%b required 1", addr, s_axi_bvalid);
        end
        resp = s_axi_bresp;
        tick();
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (s_axi_arready !== 1'b1 && n < 20) begin tick(); n++; end
        tick();
        s_axi_arvalid = 1'b0;
        total++;
        if (s_axi_rvalid !== 1'b1) begin
            bad++;
            $display("FAIL read_rvalid addr=%h got=%b required 1", addr, s_axi_rvalid);
        end
        data = s_axi_rdata;
        resp = s_axi_rresp;
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        total++;
        if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL read_arready_return addr=%h arready=%b rvalid=%b required 1/0",
                     addr, s_axi_arready, s_axi_rvalid);
        end
    endtask

    task automatic test_reset;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
             ctrl_start, irq, s_axi_bresp, s_axi_rresp, ctrl_mode, s_axi_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs aw=%b w=%b ar=%b b=%b r=%b st=%b irq=%b rdata=%h required all 0",
                     s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
                     ctrl_start, irq, s_axi_rdata);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        total++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            bad++;
            $display("FAIL reset_release_ready got=%b required 111",
                     {s_axi_awready, s_axi_wready, s_axi_arready});
        end
    endtask

    task automatic test_scratch0;
        logic [31:0] d;
        logic [1:0]  r;
        s_axi_awaddr  = 8'h08;
        s_axi_wdata   = 32'hDEADBEEF;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b0;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        total++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b000) begin
            bad++;
            $display("FAIL s0_after_hs got=%b required 000", {s_axi_awready, s_axi_wready, s_axi_bvalid});
        end
        tick();
        total++;
        if ({s_axi_bvalid, s_axi_bresp} !== 3'b100) begin
            bad++;
            $display("FAIL s0_bresp_latency got=%b required 100", {s_axi_bvalid, s_axi_bresp});
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        total++;
        if (s_axi_bvalid !== 1'b0) begin
            bad++;
            $display("FAIL s0_bvalid_drop got=%b required 0", s_axi_bvalid);
        end
        axi_read(8'h08, d, r);
        total++;
        if (d !== 32'hDEADBEEF || r !== 2'b00) begin
            bad++;
            $display("FAIL s0_readback data=%h resp=%b required deadbeef/00", d, r);
        end
    endtask

    task automatic test_w_before_aw;
        logic [31:0] d;
        logic [1:0]  r;
        s_axi_wdata  = 32'h12345678;
        s_axi_wstrb  = 4'hF;
        s_axi_wvalid = 1'b1;
        s_axi_bready = 1'b0;
        tick();
        s_axi_wvalid = 1'b0;
        total++;
        if ({s_axi_wready, s_axi_awready} !== 2'b01) begin
            bad++;
            $display("FAIL wfirst_ready got=%b required 01", {s_axi_wready, s_axi_awready});
        end
        tick(); tick();
        s_axi_awaddr  = 8'h0C;
        s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        total++;
        if (s_axi_bvalid !== 1'b0) begin
            bad++;
            $display("FAIL wfirst_commit_cycle bvalid=%b required 0", s_axi_bvalid);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({s_axi_bvalid, s_axi_awready, s_axi_wready, s_axi_bresp} !== 5'b10000) begin
                bad++;
                $display("FAIL wfirst_hold cyc=%0d got=%b required 10000", i,
                         {s_axi_bvalid, s_axi_awready, s_axi_wready, s_axi_bresp});
            end
            tick();
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        total++;
        if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b011) begin
            bad++;
            $display("FAIL wfirst_after_b got=%b required 011", {s_axi_bvalid, s_axi_awready, s_axi_wready});
        end
        tick();
        total++;
        if (s_axi_bvalid !== 1'b0) begin
            bad++;
            $display("FAIL wfirst_single_commit bvalid=%b required 0", s_axi_bvalid);
        end
        axi_read(8'h0C, d, r);
        total++;
        if (d !== 32'h12345678) begin
            bad++;
            $display("FAIL wfirst_readback data=%h required 12345678", d);
        end
    endtask

    task automatic test_strobes;
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h0C, 32'hFFFFFFFF, 4'hF, r);
        axi_write(8'h0C, 32'h00000000, 4'b0101, r);
        axi_read(8'h0C, d, r);
        total++;
        if (d !== 32'hFF00FF00) begin
            bad++;
            $display("FAIL strobe_readback data=%h required ff00ff00", d);
        end
    endtask

    task automatic test_ctrl_irq;
        logic [31:0] d;
        logic [1:0]  r;
        s_axi_awaddr  = 8'h00;
        s_axi_wdata   = 32'h31;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        total++;
        if (ctrl_start !== 1'b0) begin
            bad++;
            $display("FAIL start_early got=%b required 0", ctrl_start);
        end
        tick();
        total++;
        if (ctrl_start !== 1'b1 || ctrl_mode !== 4'd3) begin
            bad++;
            $display("FAIL start_pulse start=%b mode=%0d required 1/3", ctrl_start, ctrl_mode);
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        total++;
        if (ctrl_start !== 1'b0) begin
            bad++;
            $display("FAIL start_width got=%b required 0", ctrl_start);
        end
        axi_read(8'h00, d, r);
        total++;
        if (d !== 32'h30) begin
            bad++;
            $display("FAIL ctrl_readback data=%h required 00000030", d);
        end
        axi_write(8'h18, 32'h1, 4'hF, r);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_idle got=%b required 0", irq);
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_set got=%b required 1", irq);
        end
        axi_read(8'h14, d, r);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL irqstat_read data=%h required 1", d);
        end
        s_axi_awaddr  = 8'h14;
        s_axi_wdata   = 32'h1;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        s_axi_bready = 1'b0;
        axi_read(8'h14, d, r);
        total++;
        if (d !== 32'h1 || irq !== 1'b1) begin
            bad++;
            $display("FAIL set_wins data=%h irq=%b required 1/1", d, irq);
        end
        axi_write(8'h14, 32'h1, 4'b1110, r);
        axi_read(8'h14, d, r);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL w1c_no_strobe data=%h required 1", d);
        end
        axi_write(8'h14, 32'h1, 4'b0001, r);
        axi_read(8'h14, d, r);
        total++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL w1c_clear data=%h irq=%b required 0/0", d, irq);
        end
    endtask

    task automatic test_unmapped;
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(8'h40, d, r);
        total++;
        if (d !== 32'h0 || r !== 2'b10) begin
            bad++;
            $display("FAIL unmapped_read data=%h resp=%b required 0/10", d, r);
        end
        axi_write(8'h40, 32'h55, 4'hF, r);
        total++;
        if (r !== 2'b10) begin
            bad++;
            $display("FAIL unmapped_write resp=%b required 10", r);
        end
        axi_write(8'h10, 32'hFFFFFFFF, 4'hF, r);
        total++;
        if (r !== 2'b00) begin
            bad++;
            $display("FAIL ro_write resp=%b required 00", r);
        end
        axi_read(8'h10, d, r);
        total++;
        if (d !== 32'h0001_0000 || r !== 2'b00) begin
            bad++;
            $display("FAIL version data=%h resp=%b required 00010000/00", d, r);
        end
        core_busy = 1'b1;
        axi_read(8'h04, d, r);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL status_busy data=%h required 1", d);
        end
        core_busy = 1'b0;
        axi_read(8'h04, d, r);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL status_idle data=%h required 0", d);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic [1:0]  r;
        s_axi_awaddr  = 8'h08;
        s_axi_wdata   = 32'h11111111;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_araddr  = 8'h08;
        s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        total++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL same_cycle_read rvalid=%b data=%h required 1/deadbeef", s_axi_rvalid, s_axi_rdata);
        end
        s_axi_rready = 1'b1;
        s_axi_bready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        s_axi_bready = 1'b0;
        axi_read(8'h08, d, r);
        total++;
        if (d !== 32'h11111111) begin
            bad++;
            $display("FAIL b2b_read1 data=%h required 11111111", d);
        end
        axi_read(8'h0C, d, r);
        total++;
        if (d !== 32'hFF00FF00) begin
            bad++;
            $display("FAIL b2b_read2 data=%h required ff00ff00", d);
        end
    endtask

    task automatic test_reset_midflight;
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h00, 32'h50, 4'hF, r);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        s_axi_araddr  = 8'h08;
        s_axi_arvalid = 1'b1;
        s_axi_awaddr  = 8'h0C;
        s_axi_wdata   = 32'hA5A5A5A5;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        tick();
        total++;
        if ({s_axi_rvalid, s_axi_bvalid, irq, ctrl_mode} !== 7'b1110101) begin
            bad++;
            $display("FAIL midflight_pre got=%b required 1110101", {s_axi_rvalid, s_axi_bvalid, irq, ctrl_mode});
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({s_axi_rvalid, s_axi_bvalid, irq, ctrl_mode, s_axi_rdata, s_axi_arready, s_axi_awready} !== '0) begin
            bad++;
            $display("FAIL midflight_async rvalid=%b bvalid=%b irq=%b mode=%0d rdata=%h required all 0",
                     s_axi_rvalid, s_axi_bvalid, irq, ctrl_mode, s_axi_rdata);
        end
        tick();
        rst = 1'b0;
        tick(); tick();
        total++;
        if (s_axi_bvalid !== 1'b0) begin
            bad++;
            $display("FAIL midflight_no_resp bvalid=%b required 0", s_axi_bvalid);
        end
        axi_read(8'h08, d, r);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL midflight_scratch0 data=%h required 0", d);
        end
        axi_read(8'h0C, d, r);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL midflight_scratch1 data=%h required 0", d);
        end
        axi_read(8'h18, d, r);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL midflight_irq_en data=%h required 0", d);
        end
    endtask

    initial begin
        test_reset();
        test_scratch0();
        test_w_before_aw();
        test_strobes();
        test_ctrl_irq();
        test_unmapped();
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required finish before 200000", $time);
        $fatal(1);
    end

endmodule

// File: doc/axi_lite_regfile_slave.md
Name: axi_lite_regfile_slave

Overview:
Synthesizable AXI-Lite slave (responder) register bank for the R4W FPGA acceleration layer. It accepts AXI-Lite read and write transactions from a host or bus master and exposes control, status, scratch, version and interrupt registers to an accelerator core. It sits between the PS/interconnect AXI-Lite port and the core's control signals.

Parameters:
ADDR_WIDTH, 8, byte address width; bits [1:0] ignored (word aligned).
DATA_WIDTH, 32, data width; fixed at 32.
VERSION, 32'h0001_0000, value returned by the VERSION register.

Ports:
clk  in  1  single clock, all logic rising-edge.
rst  in  1  asynchronous active-high reset.
s_axi_awaddr  in  ADDR_WIDTH  write address.
s_axi_awprot  in  3  ignored.
s_axi_awvalid  in  1  write address valid.
s_axi_awready  out  1  write address ready.
s_axi_wdata  in  32  write data.
s_axi_wstrb  in  4  byte strobes.
s_axi_wvalid  in  1  write data valid.
s_axi_wready  out  1  write data ready.
s_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
s_axi_bvalid  out  1  write response valid.
s_axi_bready  in  1  write response ready.
s_axi_araddr  in  ADDR_WIDTH  read address.
s_axi_arprot  in  3  ignored.
s_axi_arvalid  in  1  read address valid.
s_axi_arready  out  1  read address ready.
s_axi_rdata  out  32  read data.
s_axi_rresp  out  2  read response.
s_axi_rvalid  out  1  read data valid.
s_axi_rready  in  1  read data ready.
core_busy  in  1  core busy level.
core_done  in  1  single-cycle done pulse from the core.
ctrl_start  out  1  single-cycle start pulse to the core.
ctrl_mode  out  4  mode field to the core.
irq  out  1  level interrupt = IRQ_STAT[0] & IRQ_EN[0].

Behaviour:
- Reset: all ready/valid outputs 0, bresp/rresp 00, rdata 0, ctrl_start 0, ctrl_mode 0, all RW registers 0, irq 0. Reset takes effect immediately, including mid-transaction. Any in-flight transaction is discarded with no response.
- Register map (word offset):
  - 0x00 CTRL RW: bit0 START reads 0; writing 1 pulses ctrl_start for exactly 1 cycle, on the cycle after the write commit. Bits[7:4] MODE drive ctrl_mode.
  - 0x04 STATUS RO: bit0 = core_busy, sampled at read.
  - 0x08 SCRATCH0 RW, full 32 bits.
  - 0x0C SCRATCH1 RW, full 32 bits.
  - 0x10 VERSION RO.
  - 0x14 IRQ_STAT W1C: bit0 is set by core_done. If set and clear land in the same cycle, set wins.
  - 0x18 IRQ_EN RW: bit0.
- Unmapped-register rules:
  - Unmapped addresses respond SLVERR, and reads return rdata 0.
  - Writes to RO registers are ignored and respond OKAY.
  - Unimplemented bits read 0.
- Byte strobes: each wstrb bit gates its byte lane on RW registers. A W1C bit is affected only if its lane strobe is set.
- Write channel:
  - AW and W are captured independently, in any order or together.
  - awready=1 while no address is held and bvalid=0; wready=1 likewise for data. Each drops the cycle after its handshake.
  - Commit happens on the cycle both address and data are held.
  - bvalid rises the next cycle and holds, with bresp stable, until bready. No new AW/W is accepted while bvalid=1.
- Read channel:
  - arready=1 while rvalid=0.
  - After an AR handshake, rvalid=1 on the next cycle with rdata/rresp registered. These hold stable until rready.
  - arready returns 1 on the cycle after the rready handshake. Maximum throughput is one read per 2 cycles.
- Read and write channels are independent and may be active concurrently. A read of a register written in the same cycle returns the pre-write value.
- STATUS/IRQ_STAT values are captured at the AR handshake cycle.

Test Plan:
- Reset, then write SCRATCH0=0xDEADBEEF with AW and W in the same cycle -> bresp OKAY 2 cycles after handshake; read 0x08 returns 0xDEADBEEF, rresp 00.
- W presented 3 cycles before AW, with bready held low 4 cycles -> single commit, bvalid held 4 cycles, awready/wready stay 0 until the B handshake.
- Write SCRATCH1=0xFFFFFFFF, then write 0x00000000 with wstrb=0101 -> read returns 0xFF00FF00.
- Write CTRL=0x31 -> ctrl_start high exactly 1 cycle, ctrl_mode=3, CTRL readback 0x30. Pulse core_done -> IRQ_STAT=1; with IRQ_EN=1, irq=1. W1C write of 1 to 0x14 in the same cycle as core_done -> IRQ_STAT stays 1.
- Read 0x40 -> rresp 10, rdata 0. Write 0x40 -> bresp 10. Write 0x10 -> bresp 00 and VERSION unchanged.
- Assert rst while rvalid=1 with rready low -> rvalid, bvalid and all registers return to 0 without waiting for a clock edge.
